carbon1_boot_top: RTL and testbench
===================================

Name: carbon1_boot_top

Overview:
- Reduced Carbon1 chip top without a CPU: a boot engine that streams flash contents to the UART.
- After reset it stretches the system reset, reads BOOT_BYTES bytes from an external SPI NOR flash (MT25Q-compatible, READ 0x03) and sends each byte out of the standard UART.
- Status is reported on GPIO pins; JTAG is a 1-bit bypass; I2C is idle.
- Sits at chip top level, connecting directly to pads and to the external flash.

Parameters:
- BOOT_ADDR, 24'h000000, flash start address of the boot read.
- BOOT_BYTES, 16, number of bytes read and forwarded (1..255).
- SPI_DIV, 2, io_clock cycles per sclk half-period; sclk = clk/(2*SPI_DIV).
- BAUD_DIV, 50, io_clock cycles per UART bit (1 Mbaud at 50 MHz).
- RST_STRETCH, 64, io_clock cycles io_sysReset_out stays high after reset release.
- HB_BITS, 12, heartbeat toggles every 2^HB_BITS cycles.

Ports:
- io_clock  in  1  system clock, 50 MHz.
- io_reset  in  1  asynchronous active-high reset.
- io_sysReset_out  out  1  stretched system reset, active-high.
- io_jtag_tms  in  1  ignored.
- io_jtag_tdi  in  1  JTAG data in.
- io_jtag_tck  in  1  JTAG clock, sampled in io_clock domain.
- io_jtag_tdo  out  1  bypass register output.
- io_uartStd_txd  out  1  UART 8N1 transmit, idle high.
- io_uartStd_rxd  in  1  ignored.
- io_uartStd_rts  out  1  constant 0 (ready).
- io_uartStd_cts  in  1  active-low clear-to-send.
- io_gpioStatus  out  4  status bits.
- io_gpio1  out  7  low 7 bits of the last flash byte.
- io_spiXip_ss  out  1  flash chip select, active-low.
- io_spiXip_sclk  out  1  SPI clock, mode 0.
- io_spiXip_mosi  out  1  SPI data to flash.
- io_spiXip_miso  in  1  SPI data from flash.
- io_i2c0_scl  inout  1  always released (Z).
- io_i2c0_sda  inout  1  always released (Z).

Behaviour:
- Reset values (io_reset high): sysReset_out=1, ss=1, sclk=0, mosi=0, txd=1, tdo=0, gpioStatus=0, gpio1=0.
- Reset stretch: sysReset_out falls exactly RST_STRETCH cycles after io_reset deasserts.
- Boot FSM states: WAIT_RST, CMD, ADDR, DATA, HOLD, DONE. Leaves WAIT_RST on the cycle after sysReset_out falls.
- CMD phase: ss low, shift 0x03 MSB first.
- ADDR phase: shift BOOT_ADDR, 24 bits MSB first.
- SPI timing, mode 0: mosi changes on sclk falling edge (first bit valid before the first rising edge); miso sampled on sclk rising edge.
- DATA phase: 8 rising edges per byte.
- HOLD: after each byte, sclk is held low with ss still low until the UART accepts the byte.
- After BOOT_BYTES bytes: ss goes high one half-period after the last falling sclk edge, then DONE. DONE is terminal until reset.
- UART: 1-byte handshake (valid/ready). Frame is start(0), 8 data bits LSB first, stop(1), each bit BAUD_DIV cycles.
- CTS: a frame starts only while cts=0. A frame already in progress completes regardless of cts.
- gpioStatus[0]: heartbeat, toggles when a free-running counter wraps, runs after the stretch.
- gpioStatus[1]: busy, high from CMD until DONE.
- gpioStatus[2]: done, high when DONE is reached and the last UART frame has finished.
- gpioStatus[3]: blank, set if the first data byte equals 0xFF; sticky until reset.
- io_gpio1: updates to the low 7 bits of each received byte when the byte completes.
- JTAG: tck passes through a 2-FF synchronizer. On a detected rising edge, tdo <= tdi.
- Reset mid-transaction: ss goes high immediately (asynchronously) and the FSM restarts from WAIT_RST.

Decomposition:
- Package carbon1_boot_pkg holds:
  - boot FSM state enum;
  - SPI_CMD_READ = 8'h03;
  - UART frame length constant (10 bits).
- Sub-module carbon1_uart_tx (8N1 transmitter with cts gating and valid/ready handshake).
- SPI engine and FSM stay in the top.

Test Plan:
- Reset release: io_reset high 200 ns then low -> sysReset_out falls 64 cycles later (1280 ns); ss stays high until then.
- Command/address: BOOT_ADDR=0 -> first 32 mosi bits sampled on rising sclk = 0x03000000; sclk period 80 ns.
- Data stream: flash preloaded 0x41..0x50 -> txd carries 16 frames 0x41..0x50, each 1 us per bit. gpio1 ends at 0x50 & 0x7F = 7'h50; gpioStatus[2]=1 and [3]=0.
- CTS stall: cts=1 during the third byte -> txd stays idle and sclk stays low with ss low. After cts=0, transmission resumes with byte 0x43.
- Blank flash: all 0xFF -> gpioStatus[3]=1 and 16 frames of 0xFF.
- JTAG bypass: tdi pattern 1,0,1,1 on tck rising edges -> tdo follows one tck later. Mid-stream reset asserted -> ss=1 and txd=1 immediately; boot restarts after the stretch.

Source files
------------

// File: rtl/carbon1_boot_pkg.sv
// carbon1_boot_pkg: shared types and constants for the flash-to-UART boot top.
//   boot_state_t    - boot engine FSM states
//   SPI_CMD_READ    - MT25Q single-line READ opcode
//   UART_FRAME_BITS - start + 8 data + stop
package carbon1_boot_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_RST,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_HOLD,
      ST_DONE
   } boot_state_t;

   localparam logic [7:0] SPI_CMD_READ    = 8'h03;
   localparam int         UART_FRAME_BITS = 10;

endpackage

// File: rtl/carbon1_uart_tx.sv
// carbon1_uart_tx: 8N1 transmitter with a one-byte valid/ready handshake.
//   clk, rst   - clock, asynchronous active-high reset
//   data/valid - byte offered by the producer
//   ready      - byte is taken on a cycle where valid && ready
//   cts        - active-low clear-to-send; gates only the start of a frame
//   txd        - serial output, idle high
//   busy       - a frame is on the line
module carbon1_uart_tx
   import carbon1_boot_pkg::*;
#(
   parameter int BAUD_DIV = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   input  logic       cts,
   output logic       txd,
   output logic       busy
);

   logic [15:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [8:0]  shift;   // remaining data bits with the stop bit on top

   // A frame already on the line ignores cts; only a new start waits for it.
   assign ready = !busy && !cts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= 1'b0;
         txd      <= 1'b1;
         shift    <= '1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else if (!busy) begin
         if (valid && ready) begin
            busy     <= 1'b1;
            txd      <= 1'b0;
            shift    <= {1'b1, data};
            bit_cnt  <= '0;
            baud_cnt <= '0;
         end
      end else if (baud_cnt == 16'(BAUD_DIV - 1)) begin
         baud_cnt <= '0;
         if (bit_cnt == 4'(UART_FRAME_BITS - 1)) begin
            busy <= 1'b0;
         end else begin
            txd     <= shift[0];
            shift   <= {1'b1, shift[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         baud_cnt <= baud_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/carbon1_boot.sv
// carbon1_boot_top: CPU-less Carbon1 top. Stretches reset, reads BOOT_BYTES
// bytes from SPI NOR flash (READ 0x03, mode 0) and sends each over the UART.
//   io_clock, io_reset         - clock, asynchronous active-high reset
//   io_sysReset_out            - stretched system reset
//   io_jtag_*                  - 1-bit bypass (tck sampled in io_clock domain)
//   io_uartStd_*               - 8N1 transmit, rts tied ready, cts active-low
//   io_gpioStatus              - {blank, done, busy, heartbeat}
//   io_gpio1                   - low 7 bits of the last flash byte
//   io_spiXip_*                - flash chip select, clock and data
//   io_i2c0_scl, io_i2c0_sda   - released
module carbon1_boot_top
   import carbon1_boot_pkg::*;
#(
   parameter logic [23:0] BOOT_ADDR   = 24'h000000,
   parameter int          BOOT_BYTES  = 16,
   parameter int          SPI_DIV     = 2,
   parameter int          BAUD_DIV    = 50,
   parameter int          RST_STRETCH = 64,
   parameter int          HB_BITS     = 12
) (
   input  logic       io_clock,
   input  logic       io_reset,
   output logic       io_sysReset_out,
   input  logic       io_jtag_tms,
   input  logic       io_jtag_tdi,
   input  logic       io_jtag_tck,
   output logic       io_jtag_tdo,
   output logic       io_uartStd_txd,
   input  logic       io_uartStd_rxd,
   output logic       io_uartStd_rts,
   input  logic       io_uartStd_cts,
   output logic [3:0] io_gpioStatus,
   output logic [6:0] io_gpio1,
   output logic       io_spiXip_ss,
   output logic       io_spiXip_sclk,
   output logic       io_spiXip_mosi,
   input  logic       io_spiXip_miso,
   inout  wire        io_i2c0_scl,
   inout  wire        io_i2c0_sda
);

   // Pins present on the pad ring but with no function in this reduced top.
   logic unused_inputs;
   assign unused_inputs = io_jtag_tms ^ io_uartStd_rxd;

   assign io_uartStd_rts = 1'b0;
   assign io_i2c0_scl    = 1'bz;
   assign io_i2c0_sda    = 1'bz;

   // ---------------- reset stretch ----------------
   logic        sys_reset;
   logic [15:0] stretch_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge io_clock or posedge io_reset) begin
      if (io_reset) begin
         sys_reset   <= 1'b1;
         stretch_cnt <= '0;
      end else if (sys_reset) begin
         if (stretch_cnt == 16'(RST_STRETCH - 1)) sys_reset <= 1'b0;
         else                                      stretch_cnt <= stretch_cnt + 16'd1;
      end
   end
   assign io_sysReset_out = sys_reset;

   // ---------------- heartbeat and JTAG bypass ----------------
   logic [HB_BITS-1:0] hb_cnt;
   logic               hb;
   logic [2:0]         tck_sync;   // [1:0] synchronizer, [2] previous sample

   always_ff @(posedge io_clock or posedge io_reset) begin
      if (io_reset) begin
         hb_cnt      <= '0;
         hb          <= 1'b0;
         tck_sync    <= '0;
         io_jtag_tdo <= 1'b0;
      end else begin
         if (!sys_reset) begin
            hb_cnt <= hb_cnt + 1'b1;
            if (&hb_cnt) hb <= ~hb;
         end
         tck_sync <= {tck_sync[1:0], io_jtag_tck};
         if (tck_sync[1] && !tck_sync[2]) io_jtag_tdo <= io_jtag_tdi;
      end
   end

   // ---------------- UART ----------------
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       tx_ready;
   logic       tx_busy;

   carbon1_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
      .clk   (io_clock),
      .rst   (io_reset),
      .data  (byte_data),
      .valid (byte_valid),
      .ready (tx_ready),
      .cts   (io_uartStd_cts),
      .txd   (io_uartStd_txd),
      .busy  (tx_busy)
   );

   // ---------------- SPI engine and boot FSM ----------------
   boot_state_t state;
   logic [15:0] div_cnt;
   logic [5:0]  bit_cnt;    // rising sclk edges in the current phase
   logic [7:0]  byte_cnt;   // bytes completed
   logic [31:0] tx_sr;      // command/address bits still to be driven
   logic [7:0]  rx_sr;
   logic        blank;
   logic        half_tick;

   assign half_tick = (div_cnt == 16'(SPI_DIV - 1));

   always_ff @(posedge io_clock or posedge io_reset) begin
      if (io_reset) begin
         state          <= ST_WAIT_RST;
         io_spiXip_ss   <= 1'b1;
         io_spiXip_sclk <= 1'b0;
         io_spiXip_mosi <= 1'b0;
         div_cnt        <= '0;
         bit_cnt        <= '0;
         byte_cnt       <= '0;
         tx_sr          <= '0;
         rx_sr          <= '0;
         byte_data      <= '0;
         byte_valid     <= 1'b0;
         blank          <= 1'b0;
         io_gpio1       <= '0;
      end else begin
         if (byte_valid && tx_ready) byte_valid <= 1'b0;

         case (state)
            ST_WAIT_RST: if (!sys_reset) begin
               state          <= ST_CMD;
               io_spiXip_ss   <= 1'b0;
               // First bit is driven now so it is valid before the first rise.
               io_spiXip_mosi <= SPI_CMD_READ[7];
               tx_sr          <= {SPI_CMD_READ[6:0], BOOT_ADDR, 1'b0};
               div_cnt        <= '0;
               bit_cnt        <= '0;
               byte_cnt       <= '0;
            end

            ST_CMD, ST_ADDR, ST_DATA: begin
               if (!half_tick) begin
                  div_cnt <= div_cnt + 16'd1;
               end else begin
                  div_cnt <= '0;
                  if (!io_spiXip_sclk) begin
                     io_spiXip_sclk <= 1'b1;
                     bit_cnt        <= bit_cnt + 6'd1;
                     rx_sr          <= {rx_sr[6:0], io_spiXip_miso};
                  end else begin
                     io_spiXip_sclk <= 1'b0;
                     if (state == ST_DATA) begin
                        // Byte completes on the falling edge after its 8th rise,
                        // which leaves sclk low for the hold.
                        if (bit_cnt == 6'd8) begin
                           byte_data  <= rx_sr;
                           byte_valid <= 1'b1;
                           io_gpio1   <= rx_sr[6:0];
                           byte_cnt   <= byte_cnt + 8'd1;
                           if (byte_cnt == 8'd0 && rx_sr == 8'hFF) blank <= 1'b1;
                           state      <= ST_HOLD;
                        end
                     end else if (bit_cnt == 6'd32) begin
                        state          <= ST_DATA;
                        bit_cnt        <= '0;
                        io_spiXip_mosi <= 1'b0;
                     end else begin
                        io_spiXip_mosi <= tx_sr[31];
                        tx_sr          <= {tx_sr[30:0], 1'b0};
                        if (bit_cnt == 6'd8) state <= ST_ADDR;
                     end
                  end
               end
            end

            ST_HOLD: begin
               if (byte_cnt == 8'(BOOT_BYTES)) begin
                  // Last byte: release the flash one half-period after the last
                  // falling edge; the byte drains to the UART from DONE.
                  if (!half_tick) begin
                     div_cnt <= div_cnt + 16'd1;
                  end else begin
                     io_spiXip_ss <= 1'b1;
                     state        <= ST_DONE;
                  end
               end else if (!byte_valid) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  div_cnt <= '0;
               end
            end

            ST_DONE: ;

            default: state <= ST_WAIT_RST;
         endcase
      end
   end

   // ---------------- status ----------------
   logic busy_r;
   logic done_r;

   always_ff @(posedge io_clock or posedge io_reset) begin
      if (io_reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state != ST_WAIT_RST) && (state != ST_DONE);
         done_r <= (state == ST_DONE) && !byte_valid && !tx_busy;
      end
   end

   assign io_gpioStatus = {blank, done_r, busy_r, hb};

endmodule

// File: tb/tb_carbon1_boot_top.sv
module tb_carbon1_boot_top;

   localparam int CLK_NS = 20;
   localparam int BIT_NS = 50 * CLK_NS;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sys_rst;
   logic       jtag_tms = 1'b0, jtag_tdi = 1'b0, jtag_tck = 1'b0, jtag_tdo;
   logic       uart_txd, uart_rxd = 1'b1, uart_rts, uart_cts = 1'b0;
   logic [3:0] gpio_status;
   logic [6:0] gpio1;
   logic       ss, sclk, mosi, miso = 1'b0;
   wire        i2c_scl, i2c_sda;

   int         n_checks = 0;
   int         n_fails  = 0;

   logic [7:0] flash_mem [16];
   int         fl_bits = 0;
   logic [31:0] fl_cmd = '0;
   time        fl_rise_t [2];

   logic [7:0] rx_q [$];
   logic       stop_q [$];
   logic       rst_seen = 1'b0;
   time        t_sys_fall = 0;
   time        t_hb_rise = 0;

   always #(CLK_NS / 2) clk = ~clk;

   carbon1_boot_top dut (
      .io_clock        (clk),
      .io_reset        (rst),
      .io_sysReset_out (sys_rst),
      .io_jtag_tms     (jtag_tms),
      .io_jtag_tdi     (jtag_tdi),
      .io_jtag_tck     (jtag_tck),
      .io_jtag_tdo     (jtag_tdo),
      .io_uartStd_txd  (uart_txd),
      .io_uartStd_rxd  (uart_rxd),
      .io_uartStd_rts  (uart_rts),
      .io_uartStd_cts  (uart_cts),
      .io_gpioStatus   (gpio_status),
      .io_gpio1        (gpio1),
      .io_spiXip_ss    (ss),
      .io_spiXip_sclk  (sclk),
      .io_spiXip_mosi  (mosi),
      .io_spiXip_miso  (miso),
      .io_i2c0_scl     (i2c_scl),
      .io_i2c0_sda     (i2c_sda)
   );

   // ---------------- flash model (mode 0, READ) ----------------
   always @(negedge ss) begin
      fl_bits = 0;
      fl_cmd  = '0;
   end

   always @(posedge sclk) begin
      if (ss === 1'b0) begin
         if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], mosi};
         if (fl_bits < 2)  fl_rise_t[fl_bits] = $time;
         fl_bits++;
      end
   end

   always @(negedge sclk) begin : fl_drive
      int         idx;
      logic [7:0] b;
      if (ss === 1'b0 && fl_bits >= 32) begin
         idx  = fl_bits - 32;
         b    = flash_mem[(int'(fl_cmd[23:0]) + idx / 8) % 16];
         miso = b[7 - (idx % 8)];
      end
   end

   // ---------------- UART monitor ----------------
   always @(posedge rst) rst_seen = 1'b1;

   initial begin : uart_mon
      logic [7:0] d;
      bit         ok;
      forever begin
         @(negedge uart_txd);
         rst_seen = 1'b0;
         ok = 1'b1;
         #(BIT_NS / 2);
         for (int i = 0; i < 8; i++) begin
            #(BIT_NS);
            if (rst_seen) begin
               ok = 1'b0;
               break;
            end
            d[i] = uart_txd;
         end
         if (ok) begin
            #(BIT_NS);
            if (!rst_seen) begin
               rx_q.push_back(d);
               stop_q.push_back(uart_txd);
            end
         end
      end
   end

   always @(negedge sys_rst) t_sys_fall = $time;
   always @(posedge gpio_status[0]) if (t_hb_rise == 0) t_hb_rise = $time;

   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic load_flash(input logic [7:0] base, input bit ramp);
      for (int i = 0; i < 16; i++) flash_mem[i] = ramp ? 8'(base + 8'(i)) : base;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      stop_q.delete();
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (gpio_status[2] !== 1'b1 && cyc < 30000) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (gpio_status[2] !== 1'b1) begin
         n_fails++;
         $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", tag, gpio_status[2], cyc);
      end
   endtask

   task automatic wait_frames(input int n, input string tag);
      int cyc = 0;
      while (rx_q.size() < n && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (rx_q.size() < n) begin
         n_fails++;
         $display("FAIL %s_frames_timeout: got %0d frames, required %0d", tag, rx_q.size(), n);
      end
   endtask

   task automatic wait_txd_low(input string tag);
      int cyc = 0;
      while (uart_txd !== 1'b0 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (uart_txd !== 1'b0) begin
         n_fails++;
         $display("FAIL %s_start_timeout: txd=%b, required 0", tag, uart_txd);
      end
   endtask

   task automatic check_stream(input logic [7:0] base, input bit ramp, input string tag);
      logic [7:0] exp, got;
      n_checks++;
      if (rx_q.size() != 16) begin
         n_fails++;
         $display("FAIL %s_count: got %0d frames, required 16", tag, rx_q.size());
      end
      for (int i = 0; i < 16; i++) begin
         exp = ramp ? 8'(base + 8'(i)) : base;
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_checks++;
         if (got !== exp || (i < stop_q.size() && stop_q[i] !== 1'b1)) begin
            n_fails++;
            $display("FAIL %s_byte%0d: got %h stop=%b, required %h stop=1", tag, i, got,
                     (i < stop_q.size()) ? stop_q[i] : 1'bx, exp);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int   cyc;
      logic ss_ok;
      repeat (5) @(negedge clk);
      n_checks += 9;
      if (sys_rst !== 1'b1)        begin n_fails++; $display("FAIL rst_sysreset: got %b, required 1", sys_rst); end
      if (ss !== 1'b1)             begin n_fails++; $display("FAIL rst_ss: got %b, required 1", ss); end
      if (sclk !== 1'b0)           begin n_fails++; $display("FAIL rst_sclk: got %b, required 0", sclk); end
      if (mosi !== 1'b0)           begin n_fails++; $display("FAIL rst_mosi: got %b, required 0", mosi); end
      if (uart_txd !== 1'b1)       begin n_fails++; $display("FAIL rst_txd: got %b, required 1", uart_txd); end
      if (jtag_tdo !== 1'b0)       begin n_fails++; $display("FAIL rst_tdo: got %b, required 0", jtag_tdo); end
      if (gpio_status !== 4'h0)    begin n_fails++; $display("FAIL rst_status: got %h, required 0", gpio_status); end
      if (gpio1 !== 7'h00)         begin n_fails++; $display("FAIL rst_gpio1: got %h, required 00", gpio1); end
      if (uart_rts !== 1'b0)       begin n_fails++; $display("FAIL rst_rts: got %b, required 0", uart_rts); end
      repeat (5) @(negedge clk);
      rst = 1'b0;
      cyc   = 0;
      ss_ok = 1'b1;
      while (sys_rst === 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ss !== 1'b1) ss_ok = 1'b0;
      end
      n_checks += 3;
      if (cyc != 64) begin n_fails++; $display("FAIL stretch_cycles: got %0d, required 64", cyc); end
      if (!ss_ok)    begin n_fails++; $display("FAIL stretch_ss_high: ss went low during stretch"); end
      @(posedge clk);
      #1;
      if (ss !== 1'b0) begin n_fails++; $display("FAIL boot_ss_low: got %b one cycle after stretch, required 0", ss); end
   endtask

   task automatic test_cmd_addr();
      int cyc = 0;
      while (fl_bits < 32 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      n_checks += 4;
      if (fl_cmd !== 32'h0300_0000) begin n_fails++; $display("FAIL cmd_addr: got %h, required 03000000", fl_cmd); end
      if (fl_rise_t[1] - fl_rise_t[0] != 4 * CLK_NS) begin
         n_fails++; $display("FAIL sclk_period: got %0t, required %0d", fl_rise_t[1] - fl_rise_t[0], 4 * CLK_NS);
      end
      if (gpio_status[1] !== 1'b1) begin n_fails++; $display("FAIL busy_high: got %b, required 1", gpio_status[1]); end
      if (ss !== 1'b0)             begin n_fails++; $display("FAIL cmd_ss: got %b, required 0", ss); end
   endtask

   task automatic test_data_stream();
      wait_done("stream");
      check_stream(8'h41, 1'b1, "stream");
      n_checks += 5;
      if (gpio1 !== 7'h50)          begin n_fails++; $display("FAIL stream_gpio1: got %h, required 50", gpio1); end
      if (gpio_status[3] !== 1'b0)  begin n_fails++; $display("FAIL stream_blank: got %b, required 0", gpio_status[3]); end
      if (gpio_status[1] !== 1'b0)  begin n_fails++; $display("FAIL stream_busy: got %b, required 0", gpio_status[1]); end
      if (t_hb_rise - t_sys_fall != 4096 * CLK_NS) begin
         n_fails++; $display("FAIL heartbeat: got %0t, required %0d", t_hb_rise - t_sys_fall, 4096 * CLK_NS);
      end
      repeat (50) @(negedge clk);
      if (ss !== 1'b1 || sclk !== 1'b0 || gpio_status[2] !== 1'b1) begin
         n_fails++; $display("FAIL done_terminal: ss=%b sclk=%b done=%b, required 1 0 1", ss, sclk, gpio_status[2]);
      end
   endtask

   task automatic test_cts_stall();
      logic txd_ok, sclk_ok, ss_ok;
      load_flash(8'h41, 1'b1);
      apply_reset();
      wait_frames(1, "cts");
      wait_txd_low("cts");
      uart_cts = 1'b1;              // frame 2 is on the line and must still finish
      wait_frames(2, "cts_inflight");
      repeat (40) @(negedge clk);
      txd_ok = 1'b1; sclk_ok = 1'b1; ss_ok = 1'b1;
      repeat (1000) begin
         @(negedge clk);
         if (uart_txd !== 1'b1) txd_ok  = 1'b0;
         if (sclk !== 1'b0)     sclk_ok = 1'b0;
         if (ss !== 1'b0)       ss_ok   = 1'b0;
      end
      n_checks += 4;
      if (!txd_ok)  begin n_fails++; $display("FAIL cts_txd_idle: txd left idle while cts=1"); end
      if (!sclk_ok) begin n_fails++; $display("FAIL cts_sclk_low: sclk toggled while cts=1"); end
      if (!ss_ok)   begin n_fails++; $display("FAIL cts_ss_low: ss released while cts=1"); end
      if (rx_q.size() != 2) begin n_fails++; $display("FAIL cts_frames: got %0d frames, required 2", rx_q.size()); end
      uart_cts = 1'b0;
      wait_done("cts");
      check_stream(8'h41, 1'b1, "cts");
   endtask

   task automatic test_blank();
      load_flash(8'hFF, 1'b0);
      apply_reset();
      wait_done("blank");
      check_stream(8'hFF, 1'b0, "blank");
      n_checks += 2;
      if (gpio_status[3] !== 1'b1) begin n_fails++; $display("FAIL blank_flag: got %b, required 1", gpio_status[3]); end
      if (gpio1 !== 7'h7F)         begin n_fails++; $display("FAIL blank_gpio1: got %h, required 7f", gpio1); end
   endtask

   task automatic test_jtag();
      logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         jtag_tdi = pat[i];
         #(200);
         n_checks++;
         if (jtag_tdo !== prev) begin n_fails++; $display("FAIL jtag_hold%0d: got %b, required %b", i, jtag_tdo, prev); end
         jtag_tck = 1'b1;
         #(200);
         n_checks++;
         if (jtag_tdo !== pat[i]) begin n_fails++; $display("FAIL jtag_bit%0d: got %b, required %b", i, jtag_tdo, pat[i]); end
         jtag_tck = 1'b0;
         prev = pat[i];
      end
   endtask

   task automatic test_mid_reset();
      int   cyc;
      logic ss_before;
      load_flash(8'h41, 1'b1);
      apply_reset();
      wait_frames(3, "midrst");
      wait_txd_low("midrst");
      ss_before = ss;
      #3;
      rst = 1'b1;
      #1;
      n_checks += 5;
      if (ss_before !== 1'b0) begin n_fails++; $display("FAIL midrst_ss_before: got %b, required 0", ss_before); end
      if (ss !== 1'b1)        begin n_fails++; $display("FAIL midrst_ss: got %b, required 1", ss); end
      if (uart_txd !== 1'b1)  begin n_fails++; $display("FAIL midrst_txd: got %b, required 1", uart_txd); end
      if (sys_rst !== 1'b1)   begin n_fails++; $display("FAIL midrst_sysreset: got %b, required 1", sys_rst); end
      if (sclk !== 1'b0)      begin n_fails++; $display("FAIL midrst_sclk: got %b, required 0", sclk); end
      repeat (10) @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      stop_q.delete();
      cyc = 0;
      while (sys_rst === 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_checks++;
      if (cyc != 64) begin n_fails++; $display("FAIL midrst_stretch: got %0d, required 64", cyc); end
      wait_done("midrst");
      check_stream(8'h41, 1'b1, "midrst");
   endtask

   initial begin
      load_flash(8'h41, 1'b1);
      test_reset();
      test_cmd_addr();
      test_data_stream();
      test_cts_stall();
      test_blank();
      test_jtag();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
